// File: rtl/bsg_fifo_drain_piso_pkg.sv
// bsg_fifo_drain_piso_pkg
//   Shared helpers for the FIFO-drain parallel-in/serial-out block.
//   safe_clog2  : index width that is never zero, even for a one-entry range.
//   piece_index : maps the running piece count of a word onto the slice of
//                 the input word that goes out at that count.
package bsg_fifo_drain_piso_pkg;

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    // MSB-first mode walks the slices downward from the top slice.
    function automatic int piece_index(input int cnt, input int els, input bit lsb_first);
        return lsb_first ? cnt : (els - 1 - cnt);
    endfunction

endpackage

// File: rtl/bsg_fifo_drain_piso_mux.sv
// bsg_fifo_drain_piso_mux
//   One-of-els_p slice selector for a flat word of els_p pieces.
//   Ports:
//     words  in   width_p*els_p  flat input word, piece k at [k*width_p +: width_p]
//     sel    in   lg_els_lp      index of the piece to forward
//     piece  out  width_p        selected piece (zero for an out-of-range index)
module bsg_fifo_drain_piso_mux
    import bsg_fifo_drain_piso_pkg::*;
#(
    parameter int width_p   = 8,
    parameter int els_p     = 4,
    parameter int lg_els_lp = safe_clog2(els_p)
) (
    input  logic [width_p*els_p-1:0] words,
    input  logic [lg_els_lp-1:0]     sel,
    output logic [width_p-1:0]       piece
);

    always_comb begin
        piece = '0;
        for (int k = 0; k < els_p; k++) begin
            if (sel == lg_els_lp'(k)) begin
                piece = words[k*width_p +: width_p];
            end
        end
    end

endmodule

// File: rtl/bsg_fifo_drain_piso.sv
// bsg_fifo_drain_piso
//   Serializes wide words taken from the head of a valid-yumi producer (for
//   example a small 1r1w FIFO) into narrow pieces on a valid-ready output.
//   The word is only yumi'd once its final piece has been loaded into the
//   output register, so the producer's head entry doubles as the input buffer.
//
//   Ports:
//     clk_i      in   1              clock
//     reset_n_i  in   1              synchronous active-low reset
//     v_i        in   1              input word valid
//     data_i     in   width_p*els_p  input word, stable until yumi_o
//     len_i      in   lg_els_lp      pieces in word minus one
//     yumi_o     out  1              word consumed this cycle
//     v_o        out  1              output piece valid (registered)
//     data_o     out  width_p        output piece (registered)
//     last_o     out  1              final piece of a word (registered)
//     ready_i    in   1              downstream accepts a piece this cycle
module bsg_fifo_drain_piso
    import bsg_fifo_drain_piso_pkg::*;
#(
    parameter int width_p     = 8,
    parameter int els_p       = 4,
    parameter int lsb_first_p = 1,
    localparam int lg_els_lp  = safe_clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    input  logic [width_p*els_p-1:0] data_i,
    input  logic [lg_els_lp-1:0]     len_i,
    output logic                     yumi_o,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    output logic                     last_o,
    input  logic                     ready_i
);

    if (els_p < 2) begin : g_bad_els
        $error("bsg_fifo_drain_piso: els_p must be at least 2");
    end

    localparam logic [lg_els_lp-1:0] last_idx = lg_els_lp'(els_p - 1);

    logic [lg_els_lp-1:0] cnt_r;
    logic                 valid_r;
    logic [width_p-1:0]   data_r;
    logic                 last_r;

    logic [lg_els_lp-1:0] len_eff;
    logic [lg_els_lp-1:0] sel;
    logic [width_p-1:0]   piece;
    logic                 at_last;
    logic                 load;

    // An out-of-range length is clamped so the counter can never run past
    // the last slice, even when els_p is not a power of two.
    assign len_eff = (len_i > last_idx) ? last_idx : len_i;
    assign at_last = (cnt_r == len_eff);

    // Output register refills when empty or when its current piece is
    // leaving this cycle; ready_i never reaches v_o combinationally.
    assign load = v_i & (~valid_r | ready_i);

    assign sel = lg_els_lp'(piece_index(int'(cnt_r), els_p, lsb_first_p != 0));

    bsg_fifo_drain_piso_mux #(
        .width_p   (width_p),
        .els_p     (els_p),
        .lg_els_lp (lg_els_lp)
    ) u_mux (
        .words (data_i),
        .sel   (sel),
        .piece (piece)
    );

    // Yumi is masked during reset so an abandoned word stays at the producer
    // head and is re-sent from piece 0.
    assign yumi_o = reset_n_i & load & at_last;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cnt_r   <= '0;
            valid_r <= 1'b0;
            data_r  <= '0;
            last_r  <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= piece;
            last_r  <= at_last;
            cnt_r   <= at_last ? '0 : cnt_r + 1'b1;
        end else if (ready_i) begin
            valid_r <= 1'b0;
        end
    end

    assign v_o    = valid_r;
    assign data_o = data_r;
    assign last_o = last_r;

    always_ff @(posedge clk_i) begin
        if (reset_n_i && v_i) begin
            assert (len_i <= last_idx)
                else $error("bsg_fifo_drain_piso: len_i %0d exceeds els_p-1", len_i);
        end
    end

endmodule

// File: tb/tb_bsg_fifo_drain_piso.sv
module tb_bsg_fifo_drain_piso;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v_i    [2];
    logic [31:0] data_i [2];
    logic [1:0]  len_i  [2];
    logic        rdy    [2];
    logic        yumi   [2];
    logic        v_o    [2];
    logic [7:0]  data_o [2];
    logic        last_o [2];

    bsg_fifo_drain_piso #(.width_p(8), .els_p(4), .lsb_first_p(1)) dut_lsb (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i[0]), .data_i(data_i[0]),
        .len_i(len_i[0]), .yumi_o(yumi[0]), .v_o(v_o[0]), .data_o(data_o[0]),
        .last_o(last_o[0]), .ready_i(rdy[0])
    );

    bsg_fifo_drain_piso #(.width_p(8), .els_p(4), .lsb_first_p(0)) dut_msb (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i[1]), .data_i(data_i[1]),
        .len_i(len_i[1]), .yumi_o(yumi[1]), .v_o(v_o[1]), .data_o(data_o[1]),
        .last_o(last_o[1]), .ready_i(rdy[1])
    );

    int n_vec = 0;
    int n_err = 0;

    // producer FIFOs
    logic [31:0] wdata [2][64];
    logic [1:0]  wlen  [2][64];
    int          head  [2];
    int          tail  [2];

    // expected output register contents and pieces already sent of head word
    logic        ev    [2];
    logic [7:0]  edat  [2];
    logic        elast [2];
    int          pos   [2];

    // pieces accepted downstream
    logic [7:0]  cdat  [2][2048];
    logic        clast [2][2048];
    int          cn    [2];
    int          ycnt  [2];

    // word-level expected stream for instance 0
    logic [7:0]  sdat  [2048];
    logic        slast [2048];
    int          sn;
    bit          track;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] piece_of(input logic [31:0] w, input int p, input bit lsb);
        int idx;
        idx = lsb ? p : 3 - p;
        return w[idx*8 +: 8];
    endfunction

    task automatic push(input int i, input logic [31:0] d, input logic [1:0] l);
        wdata[i][tail[i] % 64] = d;
        wlen[i][tail[i] % 64]  = l;
        tail[i]++;
    endtask

    task automatic clear_cap();
        for (int i = 0; i < 2; i++) begin
            cn[i]   = 0;
            ycnt[i] = 0;
        end
    endtask

    task automatic cycle();
        for (int i = 0; i < 2; i++) begin
            v_i[i]    = (head[i] != tail[i]);
            data_i[i] = v_i[i] ? wdata[i][head[i] % 64] : $urandom;
            len_i[i]  = v_i[i] ? wlen[i][head[i] % 64] : 2'(0);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            bit ld;
            bit fin;
            ld  = rst_n && v_i[i] && (!ev[i] || rdy[i]);
            fin = ld && (pos[i] == int'(len_i[i]));
            chk($sformatf("yumi%0d", i), yumi[i], fin);
            if (yumi[i]) ycnt[i]++;
            if (ev[i] && rdy[i] && cn[i] < 2048) begin
                cdat[i][cn[i]]  = edat[i];
                clast[i][cn[i]] = elast[i];
                cn[i]++;
            end
            if (!rst_n) begin
                ev[i] = 0; edat[i] = 8'h00; elast[i] = 0; pos[i] = 0;
            end else if (ld) begin
                edat[i]  = piece_of(data_i[i], pos[i], i == 0);
                elast[i] = fin;
                ev[i]    = 1;
                pos[i]   = fin ? 0 : pos[i] + 1;
            end else if (rdy[i]) begin
                ev[i] = 0;
            end
            if (fin) begin
                if (i == 0 && track) begin
                    for (int k = 0; k <= int'(len_i[i]); k++) begin
                        if (sn < 2048) begin
                            sdat[sn]  = piece_of(data_i[i], k, 1'b1);
                            slast[sn] = (k == int'(len_i[i]));
                            sn++;
                        end
                    end
                end
                head[i]++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("v_o%0d", i), v_o[i], ev[i]);
            chk($sformatf("data_o%0d", i), data_o[i], edat[i]);
            chk($sformatf("last_o%0d", i), last_o[i], elast[i]);
        end
    endtask

    task automatic chk_word0(input string tag, input int base, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_d"}, cdat[0][base + k], piece_of(w, k, 1'b1));
            chk({tag, "_l"}, clast[0][base + k], k == 3);
        end
    endtask

    initial begin
        rst_n = 0;
        track = 0;
        sn    = 0;
        for (int i = 0; i < 2; i++) begin
            rdy[i] = 1; v_i[i] = 0; data_i[i] = 0; len_i[i] = 0;
            head[i] = 0; tail[i] = 0;
            ev[i] = 0; edat[i] = 0; elast[i] = 0; pos[i] = 0;
        end
        clear_cap();
        @(negedge clk);
        cycle();
        cycle();
        rst_n = 1;

        // single word, LSB first
        clear_cap();
        push(0, 32'hDDCCBBAA, 2'd3);
        repeat (6) cycle();
        chk("t1_count", cn[0], 4);
        chk_word0("t1", 0, 32'hDDCCBBAA);
        chk("t1_yumi", ycnt[0], 1);

        // MSB first, two pieces
        clear_cap();
        push(1, 32'h11223344, 2'd1);
        repeat (4) cycle();
        chk("t2_count", cn[1], 2);
        chk("t2_d0", cdat[1][0], 8'h11);
        chk("t2_d1", cdat[1][1], 8'h22);
        chk("t2_l0", clast[1][0], 0);
        chk("t2_l1", clast[1][1], 1);
        chk("t2_yumi", ycnt[1], 1);

        // backpressure while BB is on the output
        clear_cap();
        push(0, 32'hDDCCBBAA, 2'd3);
        cycle();
        cycle();
        rdy[0] = 0;
        repeat (3) begin
            cycle();
            chk("t3_hold", data_o[0], 8'hBB);
            chk("t3_noyumi", ycnt[0], 0);
        end
        rdy[0] = 1;
        repeat (5) cycle();
        chk("t3_count", cn[0], 4);
        chk_word0("t3", 0, 32'hDDCCBBAA);
        chk("t3_yumi", ycnt[0], 1);

        // back-to-back words, no bubble
        clear_cap();
        push(0, 32'hDDCCBBAA, 2'd3);
        push(0, 32'h44332211, 2'd3);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("t4_nobubble", v_o[0], 1);
        end
        repeat (3) cycle();
        chk("t4_count", cn[0], 8);
        chk_word0("t4a", 0, 32'hDDCCBBAA);
        chk_word0("t4b", 4, 32'h44332211);
        chk("t4_yumi", ycnt[0], 2);

        // single-piece words
        clear_cap();
        push(0, 32'h000000A1, 2'd0);
        push(0, 32'h000000A2, 2'd0);
        push(0, 32'h000000A3, 2'd0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t5_yumi_run", ycnt[0], k + 1);
        end
        repeat (3) cycle();
        chk("t5_count", cn[0], 3);
        for (int k = 0; k < 3; k++) begin
            chk("t5_d", cdat[0][k], 8'hA1 + 8'(k));
            chk("t5_l", clast[0][k], 1);
        end

        // reset in the middle of a word
        clear_cap();
        push(0, 32'hDDCCBBAA, 2'd3);
        cycle();
        cycle();
        rdy[0] = 0;
        rst_n  = 0;
        cycle();
        chk("t6_vdrop", v_o[0], 0);
        chk("t6_noyumi", ycnt[0], 0);
        rst_n  = 1;
        rdy[0] = 1;
        repeat (6) cycle();
        chk("t6_count", cn[0], 5);
        chk("t6_first", cdat[0][0], 8'hAA);
        chk_word0("t6", 1, 32'hDDCCBBAA);
        chk("t6_yumi", ycnt[0], 1);

        // random traffic with stream scoreboard
        clear_cap();
        sn    = 0;
        track = 1;
        repeat (800) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 2) == 0 && (tail[i] - head[i]) < 60)
                    push(i, $urandom, 2'($urandom_range(0, 3)));
                rdy[i] = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end
        rdy[0] = 1;
        rdy[1] = 1;
        for (int k = 0; k < 400 && (head[0] != tail[0] || head[1] != tail[1]); k++) cycle();
        repeat (3) cycle();
        chk("rnd_drained0", head[0], tail[0]);
        chk("rnd_drained1", head[1], tail[1]);
        chk("rnd_count", cn[0], sn);
        for (int k = 0; k < sn && k < cn[0]; k++) begin
            chk("rnd_d", cdat[0][k], sdat[k]);
            chk("rnd_l", clast[0][k], slast[k]);
        end
        track = 0;

        // random traffic with occasional resets
        repeat (400) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 2) == 0 && (tail[i] - head[i]) < 60)
                    push(i, $urandom, 2'($urandom_range(0, 3)));
                rdy[i] = ($urandom_range(0, 3) != 0);
            end
            rst_n = ($urandom_range(0, 29) != 0);
            cycle();
        end
        rst_n = 1;
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
